ansi_colour_decoder: RTL
========================

# ansi_colour_decoder

Synthesisable decoder for the ANSI SGR colour escapes produced by the testbench colour utilities (ESC '[' code 'm'). It accepts a byte stream over a valid/ready handshake, strips the escape sequences, and emits each printable byte tagged with the colour in force when it arrived. It sits between a byte source, such as a UART receiver or log-capture FIFO, and a display or checker that needs plain text plus a colour attribute.

## Interface
Parameters:
- MAX_DIGITS, 3: maximum decimal digits per SGR parameter; sets the accumulator width to 10 bits.
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_data  in  8  input byte.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  8  printable byte.
- out_colour  out  3  colour tag: WHITE=0, BLUE=1, YELLOW=2, RED=3, GREEN=4.
- seq_err  out  1  one-cycle pulse on a malformed or unsupported sequence.
- err_count  out  ERR_CNT_W  saturating count of seq_err pulses.

## Operation
- The FSM has three states: TEXT, ESC_SEEN and CSI.
- TEXT:
  - Byte 0x1B → ESC_SEEN; nothing is output.
  - Any other byte → loaded into the output register with the current colour.
- ESC_SEEN:
  - Byte '[' (0x5B) → CSI; clear the accumulator, the digit count and the pending colour (pending = current colour).
  - Any other byte → seq_err; both bytes are dropped; → TEXT.
- CSI:
  - Digit '0'-'9': acc = acc*10 + digit; digit count increments.
  - A digit that would exceed MAX_DIGITS → seq_err, → TEXT, colour unchanged.
  - ';' or 'm' terminates the current parameter and maps it into pending: 0→WHITE, 37→WHITE, 94→BLUE, 33→YELLOW, 31→RED, 32→GREEN.
  - An empty parameter (no digits) maps as 0.
  - Any other value → seq_err and abort to TEXT; current colour unchanged and the sequence is discarded.
  - ';' clears acc and the digit count and stays in CSI.
  - 'm' commits pending to the current colour and returns to TEXT. The last valid parameter wins.
  - Any other byte in CSI → seq_err, abort to TEXT, colour unchanged; the offending byte is dropped.
- Escape bytes are never output.
- Colour changes apply to the first printable byte accepted after the terminating 'm'.
- err_count increments on each seq_err and holds at all-ones.

## Timing
- Reset values: out_valid=0, out_data=0, out_colour=WHITE, seq_err=0, err_count=0. Internally, FSM=TEXT, current colour=WHITE, acc=0.
- in_ready = !out_valid || out_ready (combinational).
  - In ESC_SEEN and CSI, in_ready is still gated the same way. This keeps the rule uniform, so an escape byte never overtakes a stalled output.
- Latency:
  - A printable byte accepted on cycle N has out_valid=1 from cycle N+1.
  - Back-to-back throughput is one byte per cycle while out_ready=1.
- out_data and out_colour are held stable while out_valid && !out_ready.
- seq_err is asserted in the cycle after the offending byte is accepted.
- A colour commit on 'm' accepted in cycle N affects a printable byte accepted in cycle N+1.
- Reset asserted mid-sequence:
  - Immediate return to TEXT, colour WHITE, and any pending output is dropped.
  - No seq_err is raised for the truncated sequence.
- 0x1B received in CSI is an illegal byte: seq_err, abort to TEXT. It does not start a new sequence.

## Test plan
- Stream "A",ESC,"[31m","B",ESC,"[0m","C", with out_ready held 1 → outputs A/0, B/3, C/0; no seq_err; 3 output beats.
- ESC,"[94;32m","x" → x tagged 4 (GREEN; last parameter wins); ESC,"[m","y" → y tagged 0.
- ESC,"[45m","z" with current colour RED → one seq_err pulse, err_count=1, z tagged 3; the bytes '4','5','m' are not output.
- ESC,"[0033m" with MAX_DIGITS=3 → seq_err on the 4th digit; the trailing 'm' is output as a printable byte with an unchanged colour.
- Back-pressure: out_ready=0 for 5 cycles while "PQ" is sent → P is held stable, in_ready=0, Q is accepted only after P is consumed; order and tags are preserved.
- Assert rst_n=0 after ESC,"[3" → after release, out_colour=WHITE and err_count=0; the next "33m" bytes are output as text.

Source files
------------

// File: rtl/ansi_colour_decoder.sv
// ansi_colour_decoder: strips ANSI SGR colour escapes and tags each printable byte with the colour in force
module ansi_colour_decoder #(
  parameter int MAX_DIGITS = 3,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [2:0]           out_colour,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int ACC_W = $clog2(10 ** MAX_DIGITS);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [2:0] WHITE = 3'd0, BLUE = 3'd1, YELLOW = 3'd2, RED = 3'd3, GREEN = 3'd4;
  typedef enum logic [1:0] {TEXT, ESC_SEEN, CSI} state_t;
  state_t           state;
  logic [2:0]       colour, code_col;
  logic [ACC_W-1:0] acc;
  logic [ACC_W+3:0] acc_next;
  logic [CNT_W-1:0] dcnt;
  logic             fire, is_digit, is_term, code_ok, err_now;
  assign in_ready = !out_valid || out_ready;
  always_comb begin
    fire     = in_valid && in_ready;
    is_digit = in_data >= 8'h30 && in_data <= 8'h39;
    is_term  = in_data == 8'h3B || in_data == 8'h6D;
    acc_next = (ACC_W+4)'(acc) * (ACC_W+4)'(10) + (ACC_W+4)'(in_data - 8'h30);
    code_ok  = acc inside {ACC_W'(0), ACC_W'(37), ACC_W'(94), ACC_W'(33), ACC_W'(31), ACC_W'(32)};
    code_col = acc == ACC_W'(94) ? BLUE :
               acc == ACC_W'(33) ? YELLOW :
               acc == ACC_W'(31) ? RED :
               acc == ACC_W'(32) ? GREEN : WHITE;
    err_now  = fire && (state == ESC_SEEN ? in_data != 8'h5B :
               state == CSI && (is_digit ? dcnt == CNT_W'(MAX_DIGITS) : !(is_term && code_ok)));
  end
  // The 'm' terminator commits the colour of the final parameter, so no separate pending register is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= TEXT;
      colour     <= WHITE;
      acc        <= '0;
      dcnt       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_colour <= WHITE;
      seq_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      seq_err <= err_now;
      if (err_now && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
      if (fire) begin
        out_valid <= state == TEXT && in_data != 8'h1B;
        if (err_now) state <= TEXT;
        else if (state == TEXT) begin
          if (in_data == 8'h1B) state <= ESC_SEEN;
          else begin
            out_data   <= in_data;
            out_colour <= colour;
          end
        end else if (state == ESC_SEEN) begin
          state <= CSI;
          acc   <= '0;
          dcnt  <= '0;
        end else if (is_digit) begin
          acc  <= ACC_W'(acc_next);
          dcnt <= dcnt + CNT_W'(1);
        end else begin
          acc  <= '0;
          dcnt <= '0;
          if (in_data == 8'h6D) begin
            colour <= code_col;
            state  <= TEXT;
          end
        end
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule
